vedic_seq_mul16: RTL and testbench

Sequenced 16x16 unsigned multiplier that time-shares one `vedic_8x8` core over four cycles. It accepts operands on a valid/ready handshake and steps the core through the four 8x8 partial products. The partial products are shift-accumulated into a 32-bit result, which is presented on a held valid/ready output. It sits between a requesting datapath and the single combinational multiplier core, and trades throughput for one core instance instead of four.

---
 rtl/vedic_seq_pkg.sv | 33 +++
 rtl/vedic_8x8.sv | 30 +++
 rtl/vedic_seq_mul16.sv | 118 +++++++++++
 tb/tb_vedic_seq_mul16.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_seq_pkg.sv
// Shared definitions for the sequenced 16x16 multiplier: state encoding,
// partial-product step numbering, shift table and datapath widths.
package vedic_seq_pkg;

    localparam int OP_W   = 16;
    localparam int CORE_W = 8;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Step order: bit 0 selects the high byte of a, bit 1 the high byte of b.
    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_HL = 2'd1;
    localparam logic [1:0] STEP_LH = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    // Left shift applied to the partial product of a given step.
    function automatic logic [4:0] shift_for(input logic [1:0] step);
        logic [4:0] sh;
        case (step)
            STEP_LL: sh = 5'd0;
            STEP_HL: sh = 5'd8;
            STEP_LH: sh = 5'd8;
            default: sh = 5'd16;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/vedic_8x8.sv
// Combinational 8x8 unsigned multiplier built Vedic-style from four 4x4
// crosswise products. carry_out is bit 16 of the final sum and is always 0
// for unsigned 8-bit operands; it is kept for interface compatibility.
module vedic_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] prod,
    output logic        carry_out
);

    logic [7:0]  w_p_ll;
    logic [7:0]  w_p_hl;
    logic [7:0]  w_p_lh;
    logic [7:0]  w_p_hh;
    logic [8:0]  w_mid;
    logic [16:0] w_sum;

    // Vertical and crosswise partial products, then combine the cross terms.
    always_comb begin
        w_p_ll = {4'd0, a[3:0]} * {4'd0, b[3:0]};
        w_p_hl = {4'd0, a[7:4]} * {4'd0, b[3:0]};
        w_p_lh = {4'd0, a[3:0]} * {4'd0, b[7:4]};
        w_p_hh = {4'd0, a[7:4]} * {4'd0, b[7:4]};
        w_mid  = {1'b0, w_p_hl} + {1'b0, w_p_lh};
        w_sum  = {1'b0, w_p_hh, w_p_ll} + {4'd0, w_mid, 4'd0};
        prod      = w_sum[15:0];
        carry_out = w_sum[16];
    end

endmodule

// File: rtl/vedic_seq_mul16.sv
// Sequenced 16x16 unsigned multiplier: one vedic_8x8 core is stepped through
// the four byte-wise partial products, shift-accumulated into a 32-bit result
// that is held on a valid/ready output until consumed.
module vedic_seq_mul16
    import vedic_seq_pkg::*;
#(
    parameter bit ACCEPT_WHILE_DONE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_prod,
    output logic        busy
);

    state_t              r_state;
    logic [1:0]          r_step;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [PROD_W-1:0]   r_acc;
    logic                r_out_valid;
    logic                r_busy;

    logic [CORE_W-1:0]   w_core_a;
    logic [CORE_W-1:0]   w_core_b;
    logic [2*CORE_W-1:0] w_core_prod;
    logic                w_unused_carry;
    logic [PROD_W-1:0]   w_pp;
    logic                w_accept;

    // Byte selection for the shared core and the shifted partial product.
    always_comb begin
        w_core_a = r_step[0] ? r_a[OP_W-1:CORE_W] : r_a[CORE_W-1:0];
        w_core_b = r_step[1] ? r_b[OP_W-1:CORE_W] : r_b[CORE_W-1:0];
        w_pp     = {{(PROD_W-2*CORE_W){1'b0}}, w_core_prod} << shift_for(r_step);
    end

    vedic_8x8 u_core (
        .a         (w_core_a),
        .b         (w_core_b),
        .prod      (w_core_prod),
        .carry_out (w_unused_carry)
    );

    // Ready depends only on state and out_ready; held low while in reset.
    always_comb begin
        in_ready = !rst &&
                   ((r_state == ST_IDLE) ||
                    ((r_state == ST_DONE) && ACCEPT_WHILE_DONE && out_ready));
        w_accept = in_valid && in_ready;
    end

    // Control FSM, step counter, operand latch and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_step      <= STEP_LL;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_acc   <= '0;
                        r_step  <= STEP_LL;
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_acc  <= r_acc + w_pp;
                    r_step <= r_step + 2'd1;
                    if (r_step == STEP_HH) begin
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_a     <= in_a;
                            r_b     <= in_b;
                            r_acc   <= '0;
                            r_step  <= STEP_LL;
                            r_busy  <= 1'b1;
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_step      <= STEP_LL;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_prod  = r_acc;
    assign busy      = r_busy;

endmodule

// File: tb/tb_vedic_seq_mul16.sv
// Directed bench for vedic_seq_mul16: latency, corner products, back-pressure,
// back-to-back streaming for both ACCEPT_WHILE_DONE settings, and mid-op reset.
module tb_vedic_seq_mul16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_ready;

    logic        in_ready1, out_valid1, busy1;
    logic [31:0] out_prod1;
    logic        in_ready0, out_valid0, busy0;
    logic [31:0] out_prod0;

    int n_checks = 0;
    int n_fail   = 0;

    vedic_seq_mul16 #(.ACCEPT_WHILE_DONE(1'b1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_prod  (out_prod1),
        .busy      (busy1)
    );

    vedic_seq_mul16 #(.ACCEPT_WHILE_DONE(1'b0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .out_prod  (out_prod0),
        .busy      (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Accept one pair, scramble inputs during BUSY, check fixed 4-cycle latency.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, {31'd0, in_ready1}, 32'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_a = ~a ^ 16'(i * 16'h1357);
            in_b = b + 16'(i);
            chk({tag, "_busy"}, {31'd0, busy1}, 32'd1);
            chk({tag, "_early_valid"}, {31'd0, out_valid1}, 32'd0);
            tick();
        end
        chk({tag, "_early_valid4"}, {31'd0, out_valid1}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, out_valid1}, 32'd1);
        chk({tag, "_prod"}, out_prod1, exp);
        chk({tag, "_busy_done"}, {31'd0, busy1}, 32'd0);
        tick();
        chk({tag, "_idle_valid"}, {31'd0, out_valid1}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, in_ready1}, 32'd1);
    endtask

    initial begin
        int v1_first, v1_second, v0_first, v0_second;
        logic [31:0] p1_first, p1_second, p0_second;
        logic        rdy1_at_first;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 16'h0;
        in_b = 16'h0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready1}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
        chk("rst_out_prod", out_prod1, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", {31'd0, in_ready1}, 32'd1);

        run_op("basic", 16'h1234, 16'h5678, 32'h0626_0060);
        run_op("maxmax", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run_op("ff_x_100", 16'h00FF, 16'h0100, 32'h0000_FF00);
        run_op("zero", 16'h0000, 16'hABCD, 32'h0000_0000);

        // Back-pressure in DONE with in_valid high and in_a toggling.
        out_ready = 1'b0;
        in_a = 16'h1111;
        in_b = 16'h0011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_valid_rise", {31'd0, out_valid1}, 32'd1);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a = (i % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
            chk("bp_in_ready", {31'd0, in_ready1}, 32'd0);
            tick();
            chk("bp_valid_held", {31'd0, out_valid1}, 32'd1);
            chk("bp_prod_held", out_prod1, 32'h0001_2221);
            chk("bp_busy", {31'd0, busy1}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", {31'd0, out_valid1}, 32'd0);
        chk("bp_release_idle", {31'd0, in_ready1}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_single_hs", {31'd0, out_valid1 | busy1}, 32'd0);
        end

        // Back-to-back streaming; both parameter settings observed together.
        do_reset();
        out_ready = 1'b1;
        in_a = 16'h0002;
        in_b = 16'h0003;
        in_valid = 1'b1;
        tick();
        in_a = 16'h0100;
        in_b = 16'h0100;
        v1_first = -1; v1_second = -1; v0_first = -1; v0_second = -1;
        p1_first = '0; p1_second = '0; p0_second = '0;
        rdy1_at_first = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            if (out_valid1) begin
                if (v1_first < 0) begin
                    v1_first = cyc;
                    p1_first = out_prod1;
                    rdy1_at_first = in_ready1;
                end else if (v1_second < 0) begin
                    v1_second = cyc;
                    p1_second = out_prod1;
                end
            end
            if (out_valid0) begin
                if (v0_first < 0) v0_first = cyc;
                else if (v0_second < 0) begin
                    v0_second = cyc;
                    p0_second = out_prod0;
                end
            end
        end
        in_valid = 1'b0;
        chk("b2b_first_lat", 32'(v1_first), 32'd4);
        chk("b2b_first_prod", p1_first, 32'h0000_0006);
        chk("b2b_ready_on_hs", {31'd0, rdy1_at_first}, 32'd1);
        chk("b2b_spacing1", 32'(v1_second - v1_first), 32'd5);
        chk("b2b_second_prod", p1_second, 32'h0001_0000);
        chk("b2b_p0_first_lat", 32'(v0_first), 32'd4);
        chk("b2b_spacing0", 32'(v0_second - v0_first), 32'd6);
        chk("b2b_p0_second_prod", p0_second, 32'h0001_0000);

        // Reset while step 2 of 0xFFFF x 0xFFFF is in flight.
        do_reset();
        in_a = 16'hFFFF;
        in_b = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, out_valid1}, 32'd0);
        chk("mid_rst_prod", out_prod1, 32'd0);
        chk("mid_rst_busy", {31'd0, busy1}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready1}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_valid", {31'd0, out_valid1}, 32'd0);
        end
        run_op("after_rst", 16'h0003, 16'h0005, 32'h0000_000F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
